// File: rtl/frame_buffer_ctrl.sv
// Double-buffered 8x8 LED frame store: rows are written into a hidden back bank,
// and the bank is copied to the displayed front bank only at the scanner's frame end.
module frame_buffer_ctrl #(
   parameter logic [5:0]  SWAP_INDEX   = 6'd63,
   parameter logic [63:0] INIT_PATTERN = 64'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [2:0]  wr_row,
   input  logic [7:0]  wr_data,
   input  logic        wr_clear,
   input  logic        wr_commit,
   output logic        commit_pending,
   input  logic        is_frame_done,
   output logic [5:0]  frame_done_index,
   output logic [63:0] memory_frame_buffer,
   output logic [7:0]  frame_count
);

   logic [63:0] r_front;
   logic [63:0] r_back;
   logic        r_pending;
   logic [7:0]  r_frame_count;

   logic        w_accept;
   logic        w_clear;
   logic        w_swap;
   logic [63:0] w_back_next;

   // The back bank is frozen for the whole time a commit waits for the frame end.
   assign w_accept = !r_pending && !rst;
   assign w_clear  = wr_clear && w_accept;
   assign w_swap   = is_frame_done && r_pending;

   // A row accepted in the same cycle as a clear keeps its new data.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_row
         logic w_row_we;
         assign w_row_we = w_accept && wr_valid && (wr_row == 3'(gi));
         assign w_back_next[8*gi +: 8] = w_row_we ? wr_data :
                                         (w_clear ? 8'h00 : r_back[8*gi +: 8]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_front       <= INIT_PATTERN;
         r_back        <= INIT_PATTERN;
         r_pending     <= 1'b0;
         r_frame_count <= 8'd0;
      end else begin
         r_back <= w_back_next;
         if (w_swap) begin
            r_front       <= r_back;
            r_pending     <= 1'b0;
            r_frame_count <= r_frame_count + 8'd1;
         end else if (wr_commit && !r_pending) begin
            r_pending <= 1'b1;
         end
      end
   end

   assign wr_ready            = w_accept;
   assign commit_pending      = r_pending;
   assign frame_done_index    = SWAP_INDEX;
   assign memory_frame_buffer = r_front;
   assign frame_count         = r_frame_count;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed-vector bench for frame_buffer_ctrl; each task drives one scenario
// and checks outputs 1 time unit after the rising edge.
module tb_frame_buffer_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid;
   logic        wr_ready;
   logic [2:0]  wr_row;
   logic [7:0]  wr_data;
   logic        wr_clear;
   logic        wr_commit;
   logic        commit_pending;
   logic        is_frame_done;
   logic [5:0]  frame_done_index;
   logic [63:0] memory_frame_buffer;
   logic [7:0]  frame_count;

   int n_vec = 0;
   int n_err = 0;

   frame_buffer_ctrl dut (
      .clk                 (clk),
      .rst                 (rst),
      .wr_valid            (wr_valid),
      .wr_ready            (wr_ready),
      .wr_row              (wr_row),
      .wr_data             (wr_data),
      .wr_clear            (wr_clear),
      .wr_commit           (wr_commit),
      .commit_pending      (commit_pending),
      .is_frame_done       (is_frame_done),
      .frame_done_index    (frame_done_index),
      .memory_frame_buffer (memory_frame_buffer),
      .frame_count         (frame_count)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_valid      = 1'b0;
      wr_row        = 3'd0;
      wr_data       = 8'h00;
      wr_clear      = 1'b0;
      wr_commit     = 1'b0;
      is_frame_done = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      #1;
   endtask

   task automatic write_row(input logic [2:0] row, input logic [7:0] data);
      wr_valid = 1'b1; wr_row = row; wr_data = data;
      cycle();
      wr_valid = 1'b0;
   endtask

   task automatic commit();
      wr_commit = 1'b1;
      cycle();
      wr_commit = 1'b0;
   endtask

   task automatic frame_done();
      is_frame_done = 1'b1;
      cycle();
      is_frame_done = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if (memory_frame_buffer !== 64'h0) begin
         n_err++; $display("FAIL reset_front got=%h exp=%h", memory_frame_buffer, 64'h0);
      end
      n_vec++;
      if (frame_count !== 8'd0) begin
         n_err++; $display("FAIL reset_count got=%0d exp=0", frame_count);
      end
      n_vec++;
      if (commit_pending !== 1'b0) begin
         n_err++; $display("FAIL reset_pending got=%b exp=0", commit_pending);
      end
      n_vec++;
      if (wr_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_ready got=%b exp=1", wr_ready);
      end
      n_vec++;
      if (frame_done_index !== 6'd63) begin
         n_err++; $display("FAIL done_index got=%0d exp=63", frame_done_index);
      end
      $display("test_reset done");
   endtask

   task automatic test_write_commit();
      write_row(3'd3, 8'hA5);
      commit();
      n_vec++;
      if (commit_pending !== 1'b1 || wr_ready !== 1'b0) begin
         n_err++; $display("FAIL commit_pending got=%b/%b exp=1/0", commit_pending, wr_ready);
      end
      n_vec++;
      if (memory_frame_buffer !== 64'h0) begin
         n_err++; $display("FAIL front_before_swap got=%h exp=%h", memory_frame_buffer, 64'h0);
      end
      frame_done();
      // Row 3 occupies bits [31:24].
      n_vec++;
      if (memory_frame_buffer !== 64'h00000000_A5000000) begin
         n_err++; $display("FAIL swap_row3 got=%h exp=%h", memory_frame_buffer, 64'h00000000_A5000000);
      end
      n_vec++;
      if (frame_count !== 8'd1 || commit_pending !== 1'b0) begin
         n_err++; $display("FAIL swap_state got=%0d/%b exp=1/0", frame_count, commit_pending);
      end
      frame_done();
      n_vec++;
      if (frame_count !== 8'd1) begin
         n_err++; $display("FAIL idle_frame_done got=%0d exp=1", frame_count);
      end
      $display("test_write_commit done");
   endtask

   task automatic test_blocked_write();
      commit();
      wr_valid = 1'b1; wr_row = 3'd0; wr_data = 8'hFF;
      #1;
      n_vec++;
      if (wr_ready !== 1'b0) begin
         n_err++; $display("FAIL blocked_ready got=%b exp=0", wr_ready);
      end
      wr_clear = 1'b1;
      cycle();
      wr_valid = 1'b0; wr_clear = 1'b0;
      commit();   // dropped: already pending
      frame_done();
      n_vec++;
      if (memory_frame_buffer !== 64'h00000000_A5000000) begin
         n_err++; $display("FAIL blocked_front got=%h exp=%h", memory_frame_buffer, 64'h00000000_A5000000);
      end
      n_vec++;
      if (frame_count !== 8'd2 || commit_pending !== 1'b0) begin
         n_err++; $display("FAIL blocked_state got=%0d/%b exp=2/0", frame_count, commit_pending);
      end
      $display("test_blocked_write done");
   endtask

   task automatic test_commit_with_frame_done();
      write_row(3'd1, 8'h3C);
      wr_commit = 1'b1; is_frame_done = 1'b1;
      cycle();
      wr_commit = 1'b0; is_frame_done = 1'b0;
      n_vec++;
      if (memory_frame_buffer !== 64'h00000000_A5000000 || frame_count !== 8'd2) begin
         n_err++; $display("FAIL same_cycle_noswap got=%h/%0d exp=%h/2", memory_frame_buffer, frame_count, 64'h00000000_A5000000);
      end
      n_vec++;
      if (commit_pending !== 1'b1) begin
         n_err++; $display("FAIL same_cycle_pending got=%b exp=1", commit_pending);
      end
      frame_done();
      n_vec++;
      if (memory_frame_buffer !== 64'h00000000_A5003C00 || frame_count !== 8'd3) begin
         n_err++; $display("FAIL same_cycle_swap got=%h/%0d exp=%h/3", memory_frame_buffer, frame_count, 64'h00000000_A5003C00);
      end
      $display("test_commit_with_frame_done done");
   endtask

   task automatic test_clear_write();
      wr_clear = 1'b1; wr_valid = 1'b1; wr_row = 3'd7; wr_data = 8'h81;
      cycle();
      wr_clear = 1'b0; wr_valid = 1'b0;
      commit();
      frame_done();
      n_vec++;
      if (memory_frame_buffer !== 64'h81000000_00000000 || frame_count !== 8'd4) begin
         n_err++; $display("FAIL clear_write got=%h/%0d exp=%h/4", memory_frame_buffer, frame_count, 64'h81000000_00000000);
      end
      $display("test_clear_write done");
   endtask

   task automatic test_reset_mid();
      write_row(3'd2, 8'h55);
      commit();
      rst = 1'b1;
      #1;
      n_vec++;
      if (wr_ready !== 1'b0) begin
         n_err++; $display("FAIL ready_in_rst got=%b exp=0", wr_ready);
      end
      cycle();
      rst = 1'b0;
      #1;
      n_vec++;
      if (commit_pending !== 1'b0 || memory_frame_buffer !== 64'h0 || frame_count !== 8'd0) begin
         n_err++; $display("FAIL reset_mid got=%b/%h/%0d exp=0/0/0", commit_pending, memory_frame_buffer, frame_count);
      end
      frame_done();
      commit();
      frame_done();
      n_vec++;
      if (memory_frame_buffer !== 64'h0 || frame_count !== 8'd1) begin
         n_err++; $display("FAIL back_reset got=%h/%0d exp=0/1", memory_frame_buffer, frame_count);
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 255; i++) begin
         commit();
         frame_done();
      end
      n_vec++;
      if (frame_count !== 8'd255) begin
         n_err++; $display("FAIL count_255 got=%0d exp=255", frame_count);
      end
      commit();
      frame_done();
      n_vec++;
      if (frame_count !== 8'd0) begin
         n_err++; $display("FAIL count_wrap got=%0d exp=0", frame_count);
      end
      $display("test_wrap done");
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_write_commit();
      test_blocked_write();
      test_commit_with_frame_done();
      test_clear_write();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
